// File: rtl/fp_conv_pkg.sv
// Shared widths, limits and types for the floating-point conversion datapath.
package fp_conv_pkg;
  localparam int EXP_W = 3;
  localparam int SIG_W = 4;

  typedef logic [EXP_W-1:0] exp_t;
  typedef logic [SIG_W-1:0] sig_t;

  localparam exp_t EXP_MAX    = 3'b111;
  localparam sig_t SIG_MAX    = 4'b1111;
  localparam sig_t SIG_RENORM = 4'b1000;
endpackage

// File: rtl/rounding_core.sv
// Combinational round-up with carry renormalisation and saturation.
// ROUNDING_SAT_FLAG_EN exposes the internal saturation decision as a port.
module rounding_core
  import fp_conv_pkg::*;
(
  input  exp_t exponent,
  input  sig_t significand,
  input  logic round_bit,
  output exp_t E,
  output sig_t F
`ifdef ROUNDING_SAT_FLAG_EN
  ,
  output logic saturated
`endif
);

  logic [SIG_W:0] sum;
  logic           carry;
  logic           sat;

  always_comb begin
    sum   = {1'b0, significand} + {{SIG_W{1'b0}}, round_bit};
    carry = sum[SIG_W];
    sat   = carry && (exponent == EXP_MAX);
    E     = exponent;
    F     = sum[SIG_W-1:0];
    // Carry-out renormalises into the exponent unless it is already at its limit.
    if (sat) begin
      E = EXP_MAX;
      F = SIG_MAX;
    end else if (carry) begin
      E = exponent + exp_t'(1);
      F = SIG_RENORM;
    end
  end

`ifdef ROUNDING_SAT_FLAG_EN
  assign saturated = sat;
`endif

endmodule

// File: rtl/rounding.sv
// Rounding stage: one register stage around rounding_core.
// ROUNDING_SAT_FLAG_EN adds the registered 'saturated' output.
module rounding
  import fp_conv_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  exp_t exponent,
  input  sig_t significand,
  input  logic round_bit,
  output logic out_valid,
`ifdef ROUNDING_SAT_FLAG_EN
  output logic saturated,
`endif
  output exp_t E,
  output sig_t F
);

  // Valid semantics: in_valid qualifies the inputs in the cycle it is high and is
  // always accepted (no ready); out_valid is in_valid delayed one cycle, and E/F
  // hold their last value while no new result arrives.

  exp_t core_e;
  sig_t core_f;
`ifdef ROUNDING_SAT_FLAG_EN
  logic core_sat;
`endif

  rounding_core u_core (
    .exponent    (exponent),
    .significand (significand),
    .round_bit   (round_bit),
    .E           (core_e),
    .F           (core_f)
`ifdef ROUNDING_SAT_FLAG_EN
    ,
    .saturated   (core_sat)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      E         <= '0;
      F         <= '0;
`ifdef ROUNDING_SAT_FLAG_EN
      saturated <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        E <= core_e;
        F <= core_f;
      end
`ifdef ROUNDING_SAT_FLAG_EN
      saturated <= in_valid && core_sat;
`endif
    end
  end

endmodule

// File: tb/tb_rounding.sv
// Scoreboard bench for the rounding stage; checks the saturated port when
// ROUNDING_SAT_FLAG_EN is defined.
module tb_rounding;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] exponent = '0;
  logic [3:0] significand = '0;
  logic       round_bit = 1'b0;
  logic       out_valid;
  logic [2:0] E;
  logic [3:0] F;
`ifdef ROUNDING_SAT_FLAG_EN
  logic       saturated;
`endif

  // {sat, E, F}
  logic [7:0] exp_q[$];
  logic [6:0] last_ef = '0;
  int         n_checks = 0;
  int         n_fail = 0;

  rounding dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .exponent    (exponent),
    .significand (significand),
    .round_bit   (round_bit),
    .out_valid   (out_valid),
`ifdef ROUNDING_SAT_FLAG_EN
    .saturated   (saturated),
`endif
    .E           (E),
    .F           (F)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: value = significand + round_bit, carry renormalises, top saturates.
  function automatic logic [7:0] model(input logic [2:0] e, input logic [3:0] s, input logic r);
    int v;
    logic [3:0] f;
    v = int'(s) + int'(r);
    if (v < 16) begin
      f = v[3:0];
      return {1'b0, e, f};
    end
    if (e == 3'b111) return 8'b1_111_1111;
    return {1'b0, e + 3'd1, 4'b1000};
  endfunction

  // driver tasks
  task automatic drive(input logic [2:0] e, input logic [3:0] s, input logic r);
    @(negedge clk);
    in_valid    = 1'b1;
    exponent    = e;
    significand = s;
    round_bit   = r;
    exp_q.push_back(model(e, s, r));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid    = 1'b0;
      exponent    = 3'($urandom_range(0, 7));
      significand = 4'($urandom_range(0, 15));
      round_bit   = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #3;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    last_ef  = '0;
    #1;
    check("rst_out_valid", {7'b0, out_valid}, 8'h00);
    check("rst_E", {5'b0, E}, 8'h00);
    check("rst_F", {4'b0, F}, 8'h00);
`ifdef ROUNDING_SAT_FLAG_EN
    check("rst_sat", {7'b0, saturated}, 8'h00);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // scoreboard monitor
  always @(posedge clk) begin
    logic       exp_valid;
    logic [7:0] exp;
    exp_valid = in_valid && rst_n;
    #1;
    check("out_valid", {7'b0, out_valid}, {7'b0, exp_valid});
    if (exp_valid) begin
      if (exp_q.size() == 0) begin
        check("queue_underflow", 8'h01, 8'h00);
      end else begin
        exp = exp_q.pop_front();
        check("EF", {1'b0, E, F}, {1'b0, exp[6:0]});
        last_ef = exp[6:0];
`ifdef ROUNDING_SAT_FLAG_EN
        check("sat", {7'b0, saturated}, {7'b0, exp[7]});
`endif
      end
    end else begin
      check("EF_hold", {1'b0, E, F}, {1'b0, last_ef});
`ifdef ROUNDING_SAT_FLAG_EN
      check("sat_idle", {7'b0, saturated}, 8'h00);
`endif
    end
  end

  // reset and stimulus
  initial begin
    #2;
    check("init_out_valid", {7'b0, out_valid}, 8'h00);
    check("init_E", {5'b0, E}, 8'h00);
    check("init_F", {4'b0, F}, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    drive(3'b010, 4'b0111, 1'b1);
    drive(3'b010, 4'b1111, 1'b1);
    drive(3'b001, 4'b1111, 1'b0);
    drive(3'b111, 4'b1111, 1'b1);
    drive(3'b011, 4'b0000, 1'b1);
    drive(3'b110, 4'b1111, 1'b1);
    idle(3);

    // exhaustive sweep, back-to-back
    for (int k = 0; k < 256; k++) begin
      logic [7:0] kv;
      kv = 8'(k);
      drive(kv[7:5], kv[4:1], kv[0]);
    end
    idle(2);

    for (int k = 0; k < 40; k++) begin
      drive(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(2);

    drive(3'b101, 4'b1010, 1'b1);
    drive(3'b100, 4'b1100, 1'b0);
    mid_reset();
    drive(3'b111, 4'b1111, 1'b1);
    drive(3'b000, 4'b1001, 1'b1);
    idle(3);

    check("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
